fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared encodings and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arbState_t;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after i_last, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    // Scan from the farthest offset down, so the closest requester after i_last wins.
    always_comb begin
        int j;
        o_idx   = '0;
        o_valid = 1'b0;
        o_gnt   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(i_last) + k) % NREQ;
            if (i_req[j]) begin
                o_idx   = IW'(j);
                o_valid = 1'b1;
            end
        end
        o_gnt[o_idx] = o_valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst lock in front of the FIFO write side.
// Optional per-requester beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int BCW   = $clog2(BURST + 1),
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                   w_clk,
    input  logic                   w_rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DSIZE-1:0]  req_data,
    input  logic                   w_full,
    output logic [NREQ-1:0]        gnt,
    output logic                   winc,
    output logic [DSIZE-1:0]       wdata,
    output logic                   busy,
    output logic [IW-1:0]          owner,
    output logic [NREQ*STAT_W-1:0] stat_cnt
);

    arbState_t       r_state, w_nextState;
    logic [IW-1:0]   r_last, w_nextLast;
    logic [IW-1:0]   r_owner, w_nextOwner;
    logic [BCW-1:0]  r_beatCnt, w_nextBeatCnt;

    logic [NREQ-1:0] w_pickGnt;
    logic [IW-1:0]   w_pickIdx;
    logic            w_pickValid;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pickGnt),
        .o_idx   (w_pickIdx),
        .o_valid (w_pickValid)
    );

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state   <= ST_IDLE;
            r_last    <= IW'(NREQ - 1);
            r_owner   <= '0;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_last    <= w_nextLast;
            r_owner   <= w_nextOwner;
            r_beatCnt <= w_nextBeatCnt;
        end
    end

    // A grant is always an accepted beat: the picker and the burst path only grant asserted requests.
    always_comb begin
        w_nextState   = r_state;
        w_nextLast    = r_last;
        w_nextOwner   = r_owner;
        w_nextBeatCnt = r_beatCnt;
        case (r_state)
            ST_IDLE: begin
                if (winc) begin
                    w_nextOwner   = w_pickIdx;
                    w_nextBeatCnt = BCW'(1);
                    if (BURST > 1) w_nextState = ST_BURST;
                    else           w_nextLast  = w_pickIdx;
                end
            end
            ST_BURST: begin
                if (!req[r_owner]) begin
                    w_nextState = ST_IDLE;
                    w_nextLast  = r_owner;
                end else if (winc) begin
                    w_nextBeatCnt = r_beatCnt + 1'b1;
                    if (r_beatCnt == BCW'(BURST - 1)) begin
                        w_nextState = ST_IDLE;
                        w_nextLast  = r_owner;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (!w_rst && !w_full) begin
            if (r_state == ST_IDLE) begin
                if (w_pickValid) gnt = w_pickGnt;
            end else if (req[r_owner]) begin
                gnt[r_owner] = 1'b1;
            end
        end
        winc  = |gnt;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) wdata = req_data[i*DSIZE +: DSIZE];
        end
        busy  = (r_state == ST_BURST);
        owner = r_owner;
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];

    // Saturating counters so a long-running requester never wraps back to a small count.
    always_ff @(posedge w_clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_rst) begin
                r_stat[i] <= '0;
            end else if (gnt[i] && req[i] && (r_stat[i] != STAT_MAX)) begin
                r_stat[i] <= r_stat[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_cnt[i*STAT_W +: STAT_W] = r_stat[i];
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
